// File: rtl/fifo_pkg.sv
// Shared definitions for the priority-class FIFO: default geometry, the
// pointer type (one wrap bit above the RAM address) and the occupancy helper.
package fifo_pkg;

  localparam int FIFO_ADDR_WIDTH = 5;
  localparam int FIFO_DATA_WIDTH = 16;

  typedef logic [FIFO_ADDR_WIDTH:0] ptr_t;

  // Words sitting in the RAM that have not been fetched yet. The pointers
  // carry one extra wrap bit, so the difference is taken modulo 2**(aw+1).
  function automatic int unsigned used_count(input int unsigned wr,
                                             input int unsigned rd,
                                             input int unsigned aw);
    return (wr - rd) & ((32'd1 << (aw + 1)) - 32'd1);
  endfunction

endpackage

// File: rtl/fifo_ram_ctrl.sv
// First-word-fall-through FIFO controller around a dual-port RAM with a
// one-cycle read. Port A writes, port B reads; the RAM's registered port-B
// output doubles as the FIFO head register, so no data is stored here.
module fifo_ram_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dina,
  output logic                  ram_enb,
  output logic                  ram_web,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [DATA_WIDTH-1:0] ram_doutb
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH:0] r_wr_ptr;
  logic [ADDR_WIDTH:0] r_rd_ptr;
  logic                r_out_valid;

  logic [ADDR_WIDTH:0] w_ram_used;
  logic [ADDR_WIDTH:0] w_count;
  logic                w_full;
  logic                w_clear;
  logic                w_push;
  logic                w_rd_issue;
  logic                w_pop;

  assign w_ram_used = (ADDR_WIDTH+1)'(used_count(32'(r_wr_ptr), 32'(r_rd_ptr), ADDR_WIDTH));
  assign w_full     = (w_ram_used == DEPTH);
  assign w_count    = w_ram_used + {{ADDR_WIDTH{1'b0}}, r_out_valid};
  assign w_clear    = rst | flush;

  // A clear cycle swallows any push or fetch so nothing lands in or leaves
  // the RAM while the pointers are being zeroed.
  assign w_push     = in_valid && !w_full && !w_clear;
  assign w_rd_issue = (w_ram_used != '0) && (!r_out_valid || out_ready) && !w_clear;
  assign w_pop      = r_out_valid && out_ready;

  // Pointer and head-valid update; rst and flush both discard everything.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_issue)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_rd_issue)
        r_out_valid <= 1'b1;
      else if (w_pop)
        r_out_valid <= 1'b0;
    end
  end

  // Status is derived only from registered pointers, so in_ready never
  // depends combinationally on in_valid.
  assign in_ready  = !w_full;
  assign full      = w_full;
  assign count     = w_count;
  assign empty     = (w_count == '0);
  assign out_valid = r_out_valid;
  assign out_data  = ram_doutb;

  assign ram_ena   = w_push;
  assign ram_wea   = w_push;
  assign ram_addra = r_wr_ptr[ADDR_WIDTH-1:0];
  assign ram_dina  = in_data;
  assign ram_enb   = w_rd_issue;
  assign ram_web   = 1'b0;
  assign ram_addrb = r_rd_ptr[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Bench for fifo_ram_ctrl: a behavioural RAM, a queue-based reference model,
// directed scenarios with literal expectations and a long random run.
module tb_fifo_ram_ctrl;

  localparam int AW    = 5;
  localparam int DW    = 16;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid, full, empty;
  logic [DW-1:0] out_data;
  logic [AW:0]   count;
  logic          ram_ena, ram_wea, ram_enb, ram_web;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [DW-1:0] ram_dina, ram_doutb;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  fifo_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .full(full), .empty(empty),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
    .ram_enb(ram_enb), .ram_web(ram_web), .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
  );

  always #5 clk = ~clk;

  // Dual-port RAM with registered port-B output that holds when not enabled.
  logic [DW-1:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'hEEEE;
    ram_doutb = 16'hBAD0;
  end
  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dina;
    if (ram_enb) ram_doutb <= mem[ram_addrb];
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference model: words held in the RAM as a queue plus a head slot.
  logic [DW-1:0] mq [$];
  bit            mhv = 1'b0;
  logic [DW-1:0] mhd = '0;

  // Advance the model with the inputs presented at this edge.
  always @(posedge clk) begin
    bit acc, fetch, pop;
    if (rst || flush) begin
      mq.delete();
      mhv = 1'b0;
    end else begin
      acc   = in_valid && (mq.size() < DEPTH);
      fetch = (mq.size() != 0) && (!mhv || out_ready);
      pop   = mhv && out_ready;
      if (fetch) begin
        mhd = mq.pop_front();
        mhv = 1'b1;
      end else if (pop) begin
        mhv = 1'b0;
      end
      if (acc) mq.push_back(in_data);
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", int'(in_ready), int'(mq.size() < DEPTH));
      chk("out_valid", int'(out_valid), int'(mhv));
      if (mhv) chk("out_data", int'(out_data), int'(mhd));
      chk("count", int'(count), mq.size() + int'(mhv));
      chk("full", int'(full), int'(mq.size() == DEPTH));
      chk("empty", int'(empty), int'((mq.size() + int'(mhv)) == 0));
      chk("count_max", int'(count <= 33), 1);
      chk("ram_web", int'(ram_web), 0);
      chk("collision", int'(ram_ena && ram_enb && (ram_addra == ram_addrb)), 0);
    end
  end

  task automatic cyc(input bit v, input logic [DW-1:0] d, input bit rdy,
                     input bit r, input bit f);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    rst       = r;
    flush     = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nxt, exp;
    bit acc;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk_en = 1'b1;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    // Single word: in RAM after the push edge, in the head after the next.
    cyc(1, 16'hA5A5, 0, 0, 0);
    chk("one_pushed_valid", int'(out_valid), 0);
    chk("one_pushed_count", int'(count), 1);
    cyc(0, 0, 0, 0, 0);
    chk("one_head_valid", int'(out_valid), 1);
    chk("one_head_data", int'(out_data), 16'hA5A5);
    chk("one_head_count", int'(count), 1);
    cyc(0, 0, 1, 0, 0);
    chk("one_pop_count", int'(count), 0);
    chk("one_pop_empty", int'(empty), 1);

    // Fill to capacity: 32 in RAM plus one in the head.
    for (int i = 0; i <= 32; i++) cyc(1, DW'(i), 0, 0, 0);
    chk("fill_full", int'(full), 1);
    chk("fill_in_ready", int'(in_ready), 0);
    chk("fill_count", int'(count), 33);
    cyc(1, 16'h0099, 0, 0, 0);
    chk("overflow_count", int'(count), 33);
    chk("overflow_head", int'(out_data), 0);

    // Drain while pushing; sequence must continue unbroken across the wrap.
    nxt = 33;
    exp = 0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin
        chk("drain_order", int'(out_data), exp);
        exp++;
      end
      acc = in_ready;
      cyc(1, DW'(nxt), 1, 0, 0);
      if (acc) nxt++;
    end

    // Back-pressure: head must hold and no fetch may be issued.
    for (int i = 0; i < 5; i++) begin
      acc = in_ready;
      cyc(1, DW'(nxt), 0, 0, 0);
      if (acc) nxt++;
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_data", int'(out_data), exp);
      chk("stall_enb", int'(ram_enb), 0);
    end

    // Mid-stream reset, then mid-stream flush, each with ten words held.
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) cyc(1, DW'(16'h0100 + i), 0, 0, 0);
    chk("pre_rst_count", int'(count), 10);
    cyc(1, 16'hDEAD, 1, 1, 0);
    chk("rst_mid_count", int'(count), 0);
    chk("rst_mid_valid", int'(out_valid), 0);
    chk("rst_mid_in_ready", int'(in_ready), 1);
    cyc(1, 16'h1234, 0, 0, 0);
    chk("rst_push_valid", int'(out_valid), 0);
    cyc(0, 0, 0, 0, 0);
    chk("rst_push_valid2", int'(out_valid), 1);
    chk("rst_push_data", int'(out_data), 16'h1234);
    for (int i = 0; i < 9; i++) cyc(1, DW'(16'h0200 + i), 0, 0, 0);
    chk("pre_flush_count", int'(count), 10);
    cyc(1, 16'hBEEF, 1, 0, 1);
    chk("flush_count", int'(count), 0);
    chk("flush_valid", int'(out_valid), 0);
    chk("flush_in_ready", int'(in_ready), 1);
    cyc(1, 16'h5678, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("flush_push_valid", int'(out_valid), 1);
    chk("flush_push_data", int'(out_data), 16'h5678);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 10000; i++) begin
      cyc(bit'($urandom_range(0, 1)), DW'($urandom), bit'($urandom_range(0, 1)),
          1'b0, ($urandom_range(0, 199) == 0));
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
